// File: rtl/conv_layer_sched.sv
// conv_layer_sched
// Sequencer that time-multiplexes one line_buffer -> conv_unit -> relu chain
// across NUM_FILTERS filters. For each filter, it:
//   - flushes the line buffer,
//   - loads 9 weights plus the bias,
//   - streams the whole image,
//   - writes every valid conv result to the feature map at a filter-indexed
//     address.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a layer pass (sampled only in IDLE)
//   busy / done / err     status: high outside IDLE / one-cycle completion
//                         pulse / sticky error
//   img_rd_en, img_addr   image memory read (1-cycle latency)
//   pixel_valid           img_rd_en delayed by one cycle, to line buffer
//   lb_flush              one-cycle line buffer clear
//   wt_rd_en, wt_addr     weight memory read, address filter*10 + k
//   wt_load, wt_sel       capture strobe and slot for weight register file
//   conv_valid            valid_out from conv_unit
//   out_wr_en, out_addr   feature-map write, address filter*OUT_PIX + count
//   filter_idx            filter currently in process
module conv_layer_sched #(
  parameter int IMG_SIZE     = 28,
  parameter int NUM_FILTERS  = 8,
  parameter int DRAIN_MAX    = 64,
  localparam int OUT_SIZE    = IMG_SIZE - 2,
  localparam int OUT_PIX     = OUT_SIZE * OUT_SIZE,
  localparam int IAW         = $clog2(IMG_SIZE * IMG_SIZE),
  localparam int WAW         = $clog2(NUM_FILTERS * 10),
  localparam int OAW         = $clog2(NUM_FILTERS * OUT_PIX),
  localparam int FW          = $clog2(NUM_FILTERS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           img_rd_en,
  output logic [IAW-1:0] img_addr,
  output logic           pixel_valid,
  output logic           lb_flush,
  output logic           wt_rd_en,
  output logic [WAW-1:0] wt_addr,
  output logic           wt_load,
  output logic [3:0]     wt_sel,
  input  logic           conv_valid,
  output logic           out_wr_en,
  output logic [OAW-1:0] out_addr,
  output logic [FW-1:0]  filter_idx
);

  localparam int CW  = $clog2(OUT_PIX + 1);
  // Shared LOAD_W / DRAIN counter; needs at least 4 bits to reach 10.
  localparam int DCW = (DRAIN_MAX > 16) ? $clog2(DRAIN_MAX) : 4;

  localparam logic [IAW-1:0] IMG_LAST   = IAW'(IMG_SIZE * IMG_SIZE - 1);
  localparam logic [CW-1:0]  OUT_PIX_C  = CW'(OUT_PIX);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);
  localparam logic [FW-1:0]  FILT_LAST  = FW'(NUM_FILTERS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e         state_q;
  logic           busy_q, done_q, err_q;
  logic           img_rd_en_q, pixel_valid_q, lb_flush_q;
  logic           wt_rd_en_q, wt_load_q;
  logic [IAW-1:0] img_addr_q;
  logic [WAW-1:0] wt_addr_q;
  logic [3:0]     wt_sel_q;
  logic [FW-1:0]  filter_idx_q;
  logic [CW-1:0]  out_count_q;
  logic [DCW-1:0] cnt_q;

  logic cap_s, stray_s;

  // First weight address of a filter.
  function automatic logic [WAW-1:0] wt_base(input logic [FW-1:0] f);
    return WAW'(f) * WAW'(10);
  endfunction

  // A conv result is accepted only while streaming/draining and the map is not full;
  // any other conv_valid is a protocol error.
  assign cap_s   = conv_valid && ((state_q == STREAM) || (state_q == DRAIN)) &&
                   (out_count_q < OUT_PIX_C);
  assign stray_s = conv_valid && !cap_s;

  assign out_wr_en = cap_s;
  assign out_addr  = OAW'(filter_idx_q) * OAW'(OUT_PIX) + OAW'(out_count_q);

  // Sequencer state, counters and all registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      img_rd_en_q   <= 1'b0;
      pixel_valid_q <= 1'b0;
      lb_flush_q    <= 1'b0;
      wt_rd_en_q    <= 1'b0;
      wt_load_q     <= 1'b0;
      img_addr_q    <= '0;
      wt_addr_q     <= '0;
      wt_sel_q      <= 4'd0;
      filter_idx_q  <= '0;
      out_count_q   <= '0;
      cnt_q         <= '0;
    end else begin
      // Pipeline companions of the read strobes.
      pixel_valid_q <= img_rd_en_q;
      wt_load_q     <= wt_rd_en_q;
      wt_sel_q      <= wt_rd_en_q ? cnt_q[3:0] : 4'd0;

      if (cap_s) begin
        out_count_q <= out_count_q + CW'(1);
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= LOAD_W;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
            filter_idx_q <= '0;
            out_count_q  <= '0;
            cnt_q        <= '0;
            lb_flush_q   <= 1'b1;
            wt_rd_en_q   <= 1'b1;
            wt_addr_q    <= wt_base('0);
          end
        end
        LOAD_W: begin
          // cnt_q is the cycle index 0..10 within the weight load.
          lb_flush_q <= 1'b0;
          cnt_q      <= cnt_q + DCW'(1);
          if (cnt_q == DCW'(9)) begin
            wt_rd_en_q <= 1'b0;
          end else if (cnt_q < DCW'(9)) begin
            wt_addr_q <= wt_addr_q + WAW'(1);
          end
          if (cnt_q == DCW'(10)) begin
            state_q     <= STREAM;
            cnt_q       <= '0;
            img_rd_en_q <= 1'b1;
            img_addr_q  <= '0;
          end
        end
        STREAM: begin
          if (img_addr_q == IMG_LAST) begin
            state_q     <= DRAIN;
            img_rd_en_q <= 1'b0;
            img_addr_q  <= '0;
            cnt_q       <= '0;
          end else begin
            img_addr_q <= img_addr_q + IAW'(1);
          end
        end
        DRAIN: begin
          if (out_count_q == OUT_PIX_C) begin
            if (filter_idx_q == FILT_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= LOAD_W;
              filter_idx_q <= filter_idx_q + FW'(1);
              out_count_q  <= '0;
              cnt_q        <= '0;
              lb_flush_q   <= 1'b1;
              wt_rd_en_q   <= 1'b1;
              wt_addr_q    <= wt_base(filter_idx_q + FW'(1));
            end
          end else if (cnt_q == DRAIN_LAST) begin
            // Conv pipeline never delivered the full map: abort the pass.
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DCW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          img_rd_en_q <= 1'b0;
          lb_flush_q  <= 1'b0;
          wt_rd_en_q  <= 1'b0;
        end
      endcase

      // Stray conv_valid wins over the clear from an accepted start.
      if (stray_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign img_rd_en   = img_rd_en_q;
  assign img_addr    = img_addr_q;
  assign pixel_valid = pixel_valid_q;
  assign lb_flush    = lb_flush_q;
  assign wt_rd_en    = wt_rd_en_q;
  assign wt_addr     = wt_addr_q;
  assign wt_load     = wt_load_q;
  assign wt_sel      = wt_sel_q;
  assign filter_idx  = filter_idx_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: IMG_SIZE=5, NUM_FILTERS=2, DRAIN_MAX=16,
// with a conv stub that emits one conv_valid per pixel at row>=2, col>=2.
module tb_conv_layer_sched;
  localparam int IMG  = 5;
  localparam int NF   = 2;
  localparam int DMAX = 16;
  localparam int IAW  = 5;
  localparam int WAW  = 5;
  localparam int OAW  = 5;
  localparam int FW   = 1;

  logic           clk, rst_n, start, conv_valid;
  logic           busy, done, err, img_rd_en, pixel_valid, lb_flush;
  logic           wt_rd_en, wt_load, out_wr_en;
  logic [IAW-1:0] img_addr;
  logic [WAW-1:0] wt_addr;
  logic [3:0]     wt_sel;
  logic [OAW-1:0] out_addr;
  logic [FW-1:0]  filter_idx;

  conv_layer_sched #(.IMG_SIZE(IMG), .NUM_FILTERS(NF), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .pixel_valid(pixel_valid),
    .lb_flush(lb_flush), .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_load(wt_load),
    .wt_sel(wt_sel), .conv_valid(conv_valid), .out_wr_en(out_wr_en),
    .out_addr(out_addr), .filter_idx(filter_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec, n_bad;
  logic stray_req, mon_clr;
  int stub_limit;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Conv stub: a pixel seen on pixel_valid in cycle t yields conv_valid in t+1.
  int px, pulses;
  logic pend;
  initial begin
    conv_valid = 1'b0; pend = 1'b0; px = 0; pulses = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        pend = 1'b0; conv_valid = 1'b0; px = 0; pulses = 0;
      end else begin
        conv_valid = pend || stray_req;
        if (lb_flush) begin
          px = 0; pulses = 0; pend = 1'b0;
        end else if (pixel_valid) begin
          pend = ((px / IMG) >= 2) && ((px % IMG) >= 2) && (pulses < stub_limit);
          if (pend) pulses++;
          px++;
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  // Monitor: logs interface activity on the falling edge.
  int flush_cnt, rd_cnt, img_bad, exp_img, wt_n, ld_n, wr_n, done_cnt, busy_cnt;
  int run, run_n, lc, fr_n;
  logic seen_rd;
  int wt_log[32], wt_cyc[32], ld_sel[32], ld_cyc[32], wr_log[64], runs[8], fr_log[8];
  initial begin
    forever begin
      @(negedge clk);
      if (mon_clr || !rst_n) begin
        flush_cnt = 0; rd_cnt = 0; img_bad = 0; exp_img = 0; wt_n = 0; ld_n = 0;
        wr_n = 0; done_cnt = 0; busy_cnt = 0; run = 0; run_n = 0; lc = 0; fr_n = 0;
        seen_rd = 1'b1;
      end else begin
        lc = lb_flush ? 0 : lc + 1;
        if (lb_flush) begin flush_cnt++; seen_rd = 1'b0; end
        if (img_rd_en) begin
          if (img_addr != exp_img[IAW-1:0]) img_bad++;
          exp_img = (exp_img == IMG * IMG - 1) ? 0 : exp_img + 1;
          rd_cnt++;
          if (!seen_rd) begin
            if (fr_n < 8) fr_log[fr_n] = lc;
            fr_n++;
            seen_rd = 1'b1;
          end
        end
        if (wt_rd_en) begin
          if (wt_n < 32) begin wt_log[wt_n] = int'(wt_addr); wt_cyc[wt_n] = lc; end
          wt_n++;
        end
        if (wt_load) begin
          if (ld_n < 32) begin ld_sel[ld_n] = int'(wt_sel); ld_cyc[ld_n] = lc; end
          ld_n++;
        end
        if (out_wr_en) begin
          if (wr_n < 64) wr_log[wr_n] = int'(out_addr);
          wr_n++;
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (pixel_valid) begin
          run++;
        end else if (run != 0) begin
          if (run_n < 8) runs[run_n] = run;
          run_n++;
          run = 0;
        end
      end
    end
  end

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Checks for a clean two-filter pass with 9 writes per filter.
  task automatic check_full_pass(input string tag);
    int bad;
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_busy_after"}, busy, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_flushes"}, flush_cnt, 2);
    check_eq({tag, "_img_reads"}, rd_cnt, 50);
    check_eq({tag, "_img_addr_seq"}, img_bad, 0);
    check_eq({tag, "_writes"}, wr_n, 18);
    bad = 0;
    for (int i = 0; i < 18; i++) if (wr_log[i] != i) bad++;
    check_eq({tag, "_wr_addr_seq"}, bad, 0);
  endtask

  logic ok;
  int bad;
  initial begin
    n_vec = 0; n_bad = 0; start = 1'b0; stray_req = 1'b0; mon_clr = 1'b0;
    stub_limit = 9; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_strobes", {busy, done, err, img_rd_en, pixel_valid, lb_flush,
                             wt_rd_en, wt_load, out_wr_en}, 0);
    check_eq("rst_addrs", {img_addr, wt_addr, out_addr, filter_idx, wt_sel}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario 1/2: normal pass, weight sequencing.
    clr_mon();
    start_pulse();
    check_eq("s1_busy_n1", busy, 1);
    check_eq("s1_flush_n1", lb_flush, 1);
    check_eq("s1_wt_addr_n1", wt_addr, 0);
    wait_done(400, ok);
    check_eq("s1_done_seen", ok, 1);
    @(posedge clk); #1;
    check_full_pass("s1");
    check_eq("s1_busy_cycles", busy_cnt, 79);
    check_eq("s1_wt_reads", wt_n, 20);
    check_eq("s1_wt_loads", ld_n, 20);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (wt_log[i] != i) bad++;
      if (wt_cyc[i] != i % 10) bad++;
      if (ld_sel[i] != i % 10) bad++;
      if (ld_cyc[i] != i % 10 + 1) bad++;
    end
    check_eq("s2_wt_seq", bad, 0);
    check_eq("s1_pv_runs", run_n, 2);
    check_eq("s1_pv_run0", runs[0], 25);
    check_eq("s1_pv_run1", runs[1], 25);
    check_eq("s1_load_len0", fr_log[0], 11);
    check_eq("s1_load_len1", fr_log[1], 11);

    // Scenario 4: only 8 results for filter 0 -> drain timeout.
    clr_mon();
    stub_limit = 8;
    start_pulse();
    wait_done(400, ok);
    check_eq("s4_done_seen", ok, 1);
    @(posedge clk); #1;
    check_eq("s4_err", err, 1);
    check_eq("s4_done_cnt", done_cnt, 1);
    check_eq("s4_flushes", flush_cnt, 1);
    check_eq("s4_writes", wr_n, 8);
    check_eq("s4_busy_cycles", busy_cnt, 53);
    check_eq("s4_busy_after", busy, 0);
    stub_limit = 9;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("s4_err_rst", err, 0);

    // Scenario 5: stray conv_valid in IDLE.
    clr_mon();
    stray_req = 1'b1;
    @(posedge clk); #1;
    stray_req = 1'b0;
    check_eq("s5_err_set", err, 1);
    @(posedge clk); #1;
    check_eq("s5_no_write", wr_n, 0);
    start_pulse();
    check_eq("s5_err_clr", err, 0);
    wait_done(400, ok);
    check_eq("s5_done_seen", ok, 1);
    @(posedge clk); #1;
    check_full_pass("s5");

    // Scenario 6: async reset mid-STREAM of filter 1, then start held high.
    clr_mon();
    start_pulse();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (filter_idx == 1'b1 && img_rd_en && img_addr == 5'd10) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("s6_reach_f1", ok, 1);
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_strobes", {busy, done, err, img_rd_en, pixel_valid, lb_flush,
                                wt_rd_en, wt_load, out_wr_en}, 0);
    check_eq("s6_rst_addrs", {img_addr, wt_addr, out_addr, filter_idx, wt_sel}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clr_mon();
    start = 1'b1;
    @(posedge clk); #1;
    check_eq("s6_restart_busy", busy, 1);
    check_eq("s6_restart_wt_addr", wt_addr, 0);
    check_eq("s6_restart_filter", filter_idx, 0);
    wait_done(400, ok);
    start = 1'b0;
    check_eq("s6_done_seen", ok, 1);
    repeat (6) begin
      @(posedge clk); #1;
    end
    check_full_pass("s6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
